// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: ALU/load/query/writeback signal bundle for the writeback controller
interface regfile_wb_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rdq;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rdq_busy;
    logic [5:0]  wb_rd;
    logic        wb_en;
    logic [31:0] wb_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_data,
        output rs1, rs2, rdq,
        input  ld_ready, rs1_busy, rs2_busy, rdq_busy,
        input  wb_rd, wb_en, wb_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_data,
        input  rs1, rs2, rdq,
        output ld_ready, rs1_busy, rs2_busy, rdq_busy,
        output wb_rd, wb_en, wb_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU results and buffered load returns into one registered regfile write stream, tracks pending load destinations
module regfile_wb_ctrl #(
    parameter int LQ_DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    regfile_wb_ctrl_if.slave bus
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);

    logic [4:0]    q_rd   [LQ_DEPTH];
    logic [31:0]   q_data [LQ_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [31:0]   pend;
    logic          wb_load;
    logic          push;
    logic          pop;
    logic          alu_win;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    assign bus.ld_ready = rst_n && count != FULL;
    assign push         = bus.ld_valid && bus.ld_ready && bus.ld_rd != 5'd0;
    assign alu_win      = bus.alu_valid && bus.alu_rd != 5'd0;
    assign pop          = !alu_win && count != '0;
    assign set_mask     = (bus.ld_issue && bus.ld_issue_rd != 5'd0) ? (32'd1 << bus.ld_issue_rd) : '0;
    assign clr_mask     = (bus.wb_en && wb_load) ? (32'd1 << bus.wb_rd[4:0]) : '0;
    assign bus.rs1_busy = bus.rs1 != 5'd0 && pend[bus.rs1];
    assign bus.rs2_busy = bus.rs2 != 5'd0 && pend[bus.rs2];
    assign bus.rdq_busy = bus.rdq != 5'd0 && pend[bus.rdq];

    // load-return storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= bus.ld_rd;
            q_data[wptr] <= bus.ld_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= push ? wptr + PW'(1) : wptr;
            rptr  <= pop ? rptr + PW'(1) : rptr;
            count <= (push && !pop) ? count + CW'(1) : (!push && pop) ? count - CW'(1) : count;
        end
    end

    // pending-load scoreboard; a set at the same edge as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= ((pend & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    // registered write port: ALU has priority, otherwise drain the load buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_en   <= 1'b0;
            bus.wb_rd   <= '0;
            bus.wb_data <= '0;
            wb_load     <= 1'b0;
        end else if (alu_win) begin
            bus.wb_en   <= 1'b1;
            bus.wb_rd   <= {1'b0, bus.alu_rd};
            bus.wb_data <= bus.alu_data;
            wb_load     <= 1'b0;
        end else if (pop) begin
            bus.wb_en   <= 1'b1;
            bus.wb_rd   <= {1'b0, q_rd[rptr]};
            bus.wb_data <= q_data[rptr];
            wb_load     <= 1'b1;
        end else begin
            bus.wb_en   <= 1'b0;
            wb_load     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed stimulus with a write-stream scoreboard for regfile_wb_ctrl
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q [$];

    regfile_wb_ctrl_if bus();

    regfile_wb_ctrl #(.LQ_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({1'b0, rd, data});
    endtask

    task automatic issue(input logic [4:0] rd, input bit must_be_free);
        bus.rdq = rd;
        #1;
        if (must_be_free)
            chk("issue_to_free_reg", {31'd0, bus.rdq_busy}, 32'd0);
        bus.ld_issue    = 1'b1;
        bus.ld_issue_rd = rd;
        step();
        bus.ld_issue = 1'b0;
    endtask

    // write-stream monitor: every write must match the next expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wb_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", bus.wb_rd, bus.wb_data);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if ({bus.wb_rd, bus.wb_data} !== e) begin
                    errors++;
                    $display("FAIL wb_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             bus.wb_rd, bus.wb_data, e[37:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_issue = 0; bus.ld_issue_rd = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rdq = 0;

        @(negedge clk);
        chk("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
        chk("rst_wb_rd", {26'd0, bus.wb_rd}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ld_ready_after_rst", {31'd0, bus.ld_ready}, 32'd1);

        // ALU write
        step();
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        expect_wb(5, 32'hDEADBEEF);
        step();
        bus.alu_valid = 0;
        @(negedge clk);
        chk("alu_wb_en", {31'd0, bus.wb_en}, 32'd1);
        step();
        @(negedge clk);
        chk("alu_wb_en_drop", {31'd0, bus.wb_en}, 32'd0);

        // load round trip
        bus.rs1 = 7;
        step();
        issue(7, 1);
        @(negedge clk);
        chk("rt_busy_after_issue", {31'd0, bus.rs1_busy}, 32'd1);
        step();
        chk("rt_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = 32'h12345678;
        expect_wb(7, 32'h12345678);
        step();
        bus.ld_valid = 0;
        @(negedge clk);
        chk("rt_wb_en_cycle1", {31'd0, bus.wb_en}, 32'd0);
        chk("rt_busy_cycle1", {31'd0, bus.rs1_busy}, 32'd1);
        step();
        @(negedge clk);
        chk("rt_wb_en_cycle2", {31'd0, bus.wb_en}, 32'd1);
        chk("rt_busy_cycle2", {31'd0, bus.rs1_busy}, 32'd1);
        step();
        @(negedge clk);
        chk("rt_busy_cleared", {31'd0, bus.rs1_busy}, 32'd0);

        // contention: ALU rd3 held three cycles while loads rd8, rd9 arrive
        expect_wb(3, 32'h3333_0001);
        expect_wb(3, 32'h3333_0002);
        expect_wb(3, 32'h3333_0003);
        expect_wb(8, 32'h8888_8888);
        expect_wb(9, 32'h9999_9999);
        step();
        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h3333_0001;
        bus.ld_valid = 1; bus.ld_rd = 8; bus.ld_data = 32'h8888_8888;
        #1 chk("ct_ready_0", {31'd0, bus.ld_ready}, 32'd1);
        step();
        bus.alu_data = 32'h3333_0002;
        bus.ld_rd = 9; bus.ld_data = 32'h9999_9999;
        #1 chk("ct_ready_1", {31'd0, bus.ld_ready}, 32'd1);
        step();
        bus.alu_data = 32'h3333_0003;
        bus.ld_valid = 0;
        @(negedge clk);
        chk("ct_full_a", {31'd0, bus.ld_ready}, 32'd0);
        step();
        bus.alu_valid = 0;
        @(negedge clk);
        chk("ct_full_b", {31'd0, bus.ld_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("ct_ready_after_pop", {31'd0, bus.ld_ready}, 32'd1);
        step();
        @(negedge clk);
        chk("ct_no_bubble", {31'd0, bus.wb_en}, 32'd1);
        step();

        // x0 handling
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hBAD0_0000;
        bus.ld_valid = 1; bus.ld_rd = 4; bus.ld_data = 32'h4444_4444;
        expect_wb(4, 32'h4444_4444);
        step();
        bus.ld_rd = 0; bus.ld_data = 32'hBAD0_0001;
        @(negedge clk);
        chk("x0_no_write_yet", {31'd0, bus.wb_en}, 32'd0);
        step();
        bus.alu_valid = 0; bus.ld_valid = 0;
        @(negedge clk);
        chk("x0_load_writes", {31'd0, bus.wb_en}, 32'd1);
        step();
        issue(0, 0);
        bus.rs1 = 0; bus.rs2 = 0; bus.rdq = 0;
        @(negedge clk);
        chk("x0_busy", {29'd0, bus.rs1_busy, bus.rs2_busy, bus.rdq_busy}, 32'd0);
        step();
        step();
        @(negedge clk);
        chk("x0_no_stale_write", {31'd0, bus.wb_en}, 32'd0);

        // set/clear collision on rd10
        bus.rs1 = 10;
        step();
        issue(10, 1);
        bus.ld_valid = 1; bus.ld_rd = 10; bus.ld_data = 32'hAAAA_0001;
        expect_wb(10, 32'hAAAA_0001);
        step();
        bus.ld_valid = 0;
        step();
        issue(10, 0);
        @(negedge clk);
        chk("collision_pend_kept", {31'd0, bus.rs1_busy}, 32'd1);
        step();
        bus.ld_valid = 1; bus.ld_rd = 10; bus.ld_data = 32'hAAAA_0002;
        expect_wb(10, 32'hAAAA_0002);
        step();
        bus.ld_valid = 0;
        step();
        step();
        @(negedge clk);
        chk("collision_final_clear", {31'd0, bus.rs1_busy}, 32'd0);

        // async reset with two buffered loads and pending bits
        step();
        issue(11, 1);
        issue(12, 1);
        bus.rs1 = 11; bus.rs2 = 12; bus.rdq = 11;
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h0000_0011;
        bus.ld_valid = 1; bus.ld_rd = 11; bus.ld_data = 32'hB11B_B11B;
        expect_wb(1, 32'h0000_0011);
        step();
        bus.alu_data = 32'h0000_0012;
        bus.ld_rd = 12; bus.ld_data = 32'hC12C_C12C;
        step();
        bus.alu_valid = 0; bus.ld_valid = 0;
        #2;
        chk("pre_rst_wb_en", {31'd0, bus.wb_en}, 32'd1);
        chk("pre_rst_busy", {29'd0, bus.rs1_busy, bus.rs2_busy, bus.rdq_busy}, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("arst_wb_en", {31'd0, bus.wb_en}, 32'd0);
        chk("arst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("arst_busy", {29'd0, bus.rs1_busy, bus.rs2_busy, bus.rdq_busy}, 32'd0);
        #8;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("post_rst_busy", {29'd0, bus.rs1_busy, bus.rs2_busy, bus.rdq_busy}, 32'd0);
        chk("exp_queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
